// File: rtl/gpio_led_ctrl.sv
// gpio_led_ctrl: per-channel LED drive (off/pass/blink/pwm) from a shared prescaler, with rising-edge trigger pulses; in: clk_i rst_n_i led_i presc_i cfg_we_i cfg_ch_i cfg_mode_i cfg_duty_i, out: led_o trig_o tick_o
module gpio_led_ctrl #(
  parameter int GPIO_NUM    = 32,
  parameter int PRESC_WIDTH = 16,
  parameter int DUTY_WIDTH  = 8,
  localparam int CW = (GPIO_NUM > 1) ? $clog2(GPIO_NUM) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic [GPIO_NUM-1:0]    led_i,
  input  logic [PRESC_WIDTH-1:0] presc_i,
  input  logic                   cfg_we_i,
  input  logic [CW-1:0]          cfg_ch_i,
  input  logic [1:0]             cfg_mode_i,
  input  logic [DUTY_WIDTH-1:0]  cfg_duty_i,
  output logic [GPIO_NUM-1:0]    led_o,
  output logic [GPIO_NUM-1:0]    trig_o,
  output logic                   tick_o
);
  typedef enum logic [1:0] {OFF, PASS, BLINK, PWM} mode_t;
  logic [PRESC_WIDTH-1:0] pcnt;
  logic [DUTY_WIDTH-1:0]  wcnt;
  logic                   blk;
  logic                   tick;
  mode_t                  mode [GPIO_NUM];
  logic [DUTY_WIDTH-1:0]  duty [GPIO_NUM];
  logic [GPIO_NUM-1:0]    nxt;
  logic [GPIO_NUM-1:0]    led_q;
  assign tick = pcnt >= presc_i;
  always_comb begin
    nxt = '0;
    for (int i = 0; i < GPIO_NUM; i++)
      nxt[i] = mode[i] == PASS  ? led_i[i] :
               mode[i] == BLINK ? led_i[i] & blk :
               mode[i] == PWM   ? led_i[i] & (wcnt < duty[i]) : 1'b0;
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pcnt   <= '0;
      wcnt   <= '0;
      blk    <= 1'b0;
      tick_o <= 1'b0;
      led_o  <= '0;
      led_q  <= '0;
      trig_o <= '0;
      for (int i = 0; i < GPIO_NUM; i++) begin
        mode[i] <= PASS;
        duty[i] <= '0;
      end
    end else begin
      pcnt   <= tick ? '0 : pcnt + 1'b1;
      wcnt   <= wcnt + DUTY_WIDTH'(tick);
      blk    <= blk ^ (tick & (&wcnt));
      tick_o <= tick;
      led_o  <= nxt;
      led_q  <= led_o;
      trig_o <= led_o & ~led_q;
      // index compare per channel: indices >= GPIO_NUM match nothing
      for (int i = 0; i < GPIO_NUM; i++)
        if (cfg_we_i && cfg_ch_i == CW'(i)) begin
          mode[i] <= mode_t'(cfg_mode_i);
          duty[i] <= cfg_duty_i;
        end
    end
  end
endmodule

// File: tb/tb_gpio_led_ctrl.sv
// tb_gpio_led_ctrl: self-checking bench for gpio_led_ctrl (table vectors + hand sequences)
module tb_gpio_led_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] led_i = '0;
  logic [15:0] presc = 16'hFFFF;
  logic        we = 1'b0;
  logic [4:0]  ch = '0;
  logic [1:0]  mode = '0;
  logic [7:0]  duty = '0;
  logic [31:0] led_o, trig_o;
  logic        tick_o;
  logic [19:0] led2_i = '1;
  logic [19:0] led2_o, trig2_o;
  logic        tick2_o;
  int total = 0;
  int bad = 0;
  typedef struct {
    logic        we;
    logic [4:0]  ch;
    logic [1:0]  mode;
    logic [7:0]  duty;
    logic [31:0] led;
    logic [31:0] exp_led;
    logic [31:0] exp_trig;
  } vec_t;
  typedef struct {
    logic [31:0] led;
    logic [31:0] trig;
  } exp_t;
  vec_t tbl [8];
  exp_t sbq [$];

  gpio_led_ctrl dut (
    .clk_i(clk), .rst_n_i(rst_n), .led_i(led_i), .presc_i(presc),
    .cfg_we_i(we), .cfg_ch_i(ch), .cfg_mode_i(mode), .cfg_duty_i(duty),
    .led_o(led_o), .trig_o(trig_o), .tick_o(tick_o)
  );
  gpio_led_ctrl #(.GPIO_NUM(20)) dut2 (
    .clk_i(clk), .rst_n_i(rst_n), .led_i(led2_i), .presc_i(presc),
    .cfg_we_i(we), .cfg_ch_i(ch), .cfg_mode_i(mode), .cfg_duty_i(duty),
    .led_o(led2_o), .trig_o(trig2_o), .tick_o(tick2_o)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [4:0] c, input logic [1:0] m, input logic [7:0] d);
    we = 1'b1;
    ch = c;
    mode = m;
    duty = d;
    cyc();
    we = 1'b0;
  endtask

  task automatic count(input int len, input int b, output int h, output int t);
    h = 0;
    t = 0;
    for (int j = 0; j < len; j++) begin
      cyc();
      h += int'(led_o[b]);
      t += int'(trig_o[b]);
    end
  endtask

  initial begin
    exp_t e;
    int n, hi, tr;
    // modes: 0 OFF, 1 PASS, 2 BLINK, 3 PWM; no ticks during the table (presc=FFFF) so wcnt=0, blk=0
    tbl[0] = '{1'b0, 5'd0,  2'd0, 8'd0, 32'h5,        32'h5,        32'h5};
    tbl[1] = '{1'b1, 5'd0,  2'd0, 8'd0, 32'h5,        32'h4,        32'h0};
    tbl[2] = '{1'b1, 5'd1,  2'd3, 8'd0, 32'hF,        32'hC,        32'hA};
    tbl[3] = '{1'b1, 5'd1,  2'd3, 8'd1, 32'hF,        32'hE,        32'h0};
    tbl[4] = '{1'b1, 5'd2,  2'd2, 8'd0, 32'hF,        32'hA,        32'h0};
    tbl[5] = '{1'b1, 5'd0,  2'd1, 8'd0, 32'h3,        32'h3,        32'h0};
    tbl[6] = '{1'b1, 5'd3,  2'd0, 8'd0, 32'h9,        32'h1,        32'h8};
    tbl[7] = '{1'b1, 5'd31, 2'd1, 8'd0, 32'h80000001, 32'h80000001, 32'h80000000};
    cyc();
    cyc();
    check("reset led_o", led_o, 32'h0);
    check("reset trig_o", trig_o, 32'h0);
    check("reset tick_o", 32'(tick_o), 32'h0);
    rst_n = 1'b1;
    foreach (tbl[k]) begin
      we = tbl[k].we;
      ch = tbl[k].ch;
      mode = tbl[k].mode;
      duty = tbl[k].duty;
      led_i = tbl[k].led;
      sbq.push_back('{tbl[k].exp_led, tbl[k].exp_trig});
      cyc();
      we = 1'b0;
      cyc();
      e = sbq.pop_front();
      check($sformatf("vec%0d led_o", k), led_o, e.led);
      check($sformatf("vec%0d trig_o", k), trig_o, e.trig);
    end
    // asynchronous reset mid-operation clears outputs with no clock edge
    rst_n = 1'b0;
    #2;
    check("async rst led_o", led_o, 32'h0);
    check("async rst trig_o", trig_o, 32'h0);
    presc = 16'd3;
    led_i = '0;
    cyc();
    rst_n = 1'b1;
    // presc=3: tick every 4 edges; presc lowered to 1 while pcnt=2 forces a tick next edge
    for (int k = 1; k <= 19; k++) begin
      cyc();
      check($sformatf("tick edge%0d", k), 32'(tick_o), 32'((k <= 14) ? (k % 4 == 0) : (k % 2 == 1)));
      if (k == 14) presc = 16'd1;
    end
    // out-of-range index on the 20-channel instance; ch5 OFF latency on the main one
    led_i = 32'h20;
    cyc();
    cyc();
    wr(5'd25, 2'd0, 8'd0);
    cyc();
    cyc();
    check("oor write dut2 led_o", 32'(led2_o), 32'hFFFFF);
    wr(5'd19, 2'd0, 8'd0);
    check("ch19 off +1 dut2", 32'(led2_o), 32'hFFFFF);
    cyc();
    check("ch19 off +2 dut2", 32'(led2_o), 32'h7FFFF);
    wr(5'd5, 2'd0, 8'd0);
    check("ch5 off +1", 32'(led_o[5]), 32'h1);
    cyc();
    check("ch5 off +2", 32'(led_o[5]), 32'h0);
    // PWM on ch2 with a tick every cycle: any 256-cycle window holds one full period
    presc = 16'd0;
    led_i = 32'h4;
    wr(5'd2, 2'd3, 8'd64);
    repeat (4) cyc();
    count(256, 2, hi, tr);
    check("pwm64 high", 32'(hi), 32'd64);
    check("pwm64 trig", 32'(tr), 32'd1);
    wr(5'd2, 2'd3, 8'd0);
    repeat (4) cyc();
    count(256, 2, hi, tr);
    check("pwm0 high", 32'(hi), 32'd0);
    check("pwm0 trig", 32'(tr), 32'd0);
    wr(5'd2, 2'd3, 8'd255);
    repeat (4) cyc();
    count(256, 2, hi, tr);
    check("pwm255 high", 32'(hi), 32'd255);
    check("pwm255 trig", 32'(tr), 32'd1);
    // reset mid-PWM: outputs drop at once, modes return to PASS, no trigger from reset itself
    rst_n = 1'b0;
    led_i = '0;
    #2;
    check("midpwm rst led_o", led_o, 32'h0);
    check("midpwm rst trig_o", trig_o, 32'h0);
    check("midpwm rst tick_o", 32'(tick_o), 32'h0);
    cyc();
    rst_n = 1'b1;
    cyc();
    check("release led_o", led_o, 32'h0);
    check("release trig_o", trig_o, 32'h0);
    led_i = 32'h25;
    cyc();
    check("pass restored led_o", led_o, 32'h25);
    cyc();
    check("pass restored trig_o", trig_o, 32'h25);
    // BLINK on ch0: high runs of 256 cycles, gated off by led_i
    led_i = 32'h1;
    wr(5'd0, 2'd2, 8'd0);
    n = 0;
    while (led_o[0] !== 1'b0 && n < 600) begin cyc(); n++; end
    check("blink wait low", 32'(n < 600), 32'h1);
    n = 0;
    while (led_o[0] !== 1'b1 && n < 600) begin cyc(); n++; end
    check("blink wait high", 32'(n < 600), 32'h1);
    n = 0;
    while (led_o[0] === 1'b1 && n < 600) begin cyc(); n++; end
    check("blink high run", 32'(n), 32'd256);
    led_i = 32'h0;
    cyc();
    cyc();
    count(300, 0, hi, tr);
    check("blink gated high", 32'(hi), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
